// File: rtl/mole_pkg.sv
// Shared state type, synchroniser depth and popcount helper for the mole game controller.
package mole_pkg;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_END  = 1'b1
  } state_t;

  localparam int SYNC_DEPTH = 2;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mole_channel.sv
// One mole: button synchroniser and edge detector, lit/dark timer, LED flop, hit/miss strobes.
module mole_channel
  import mole_pkg::*;
#(
  parameter int               CNT_W     = 28,
  parameter logic [CNT_W-1:0] ON_TICKS  = CNT_W'(25000000),
  parameter logic [CNT_W-1:0] OFF_TICKS = CNT_W'(75000000)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  input  logic i_run,
  input  logic i_kill,
  input  logic i_init,
  output logic o_led,
  output logic o_hit,
  output logic o_miss
);

  localparam logic [CNT_W-1:0] ON_LAST  = ON_TICKS - CNT_W'(1);
  localparam logic [CNT_W-1:0] OFF_LAST = OFF_TICKS - CNT_W'(1);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_prev;
  logic                  r_led;
  logic [CNT_W-1:0]      r_timer;
  logic                  w_press;

  assign w_press = r_prev & ~r_sync[SYNC_DEPTH-1];
  assign o_hit   = w_press & r_led & i_run;
  assign o_miss  = w_press & ~r_led & i_run;
  assign o_led   = r_led;

  // The synchroniser only follows the pin; a game restart leaves it alone so a
  // held button cannot fabricate a fresh press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= '1;
      r_prev  <= 1'b1;
      r_led   <= 1'b1;
      r_timer <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_btn_n};
      r_prev <= r_sync[SYNC_DEPTH-1];
      if (i_init) begin
        r_led   <= 1'b1;
        r_timer <= '0;
      end else if (i_kill) begin
        r_led <= 1'b0;
      end else if (i_run) begin
        if (w_press && r_led) begin
          r_led   <= 1'b0;
          r_timer <= '0;
        end else if (r_led && r_timer == ON_LAST) begin
          r_led   <= 1'b0;
          r_timer <= '0;
        end else if (!r_led && r_timer == OFF_LAST) begin
          r_led   <= 1'b1;
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole controller: mole channels, pending-hit score injection, win detection and restart.
//   state   | meaning
//   ST_PLAY | moles cycling, hits accumulate and are injected into the score
//   ST_END  | win reached, LEDs dark, waiting for holdoff then a restart press
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int                         NUM_MOLES       = 4,
  parameter int                         CNT_W           = 28,
  parameter int                         ON_TICKS        = 25000000,
  parameter logic [NUM_MOLES*CNT_W-1:0] OFF_TICKS_VEC   = {28'd175000000, 28'd100000000,
                                                           28'd125000000, 28'd75000000},
  parameter int                         SCORE_W         = 32,
  parameter int                         PEND_W          = 8,
  parameter int                         WIN_SCORE       = 12,
  parameter int                         RESTART_HOLDOFF = 1000,
  parameter int                         MISS_EN         = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_MOLES-1:0] btn_n,
  input  logic                 btn_restart_n,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic                 end_led,
  input  logic [SCORE_W-1:0]   score_total,
  output logic                 inj_valid,
  output logic [SCORE_W-1:0]   inj_delta,
  input  logic                 inj_ack,
  output logic [7:0]           miss_count,
  output logic                 game_reset,
  output logic                 in_game
);

  localparam int                HOLD_W   = $clog2(RESTART_HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESTART_HOLDOFF);

  state_t                r_state, w_state_next;
  logic [SYNC_DEPTH-1:0] r_rst_sync;
  logic                  r_rst_prev;
  logic                  w_restart_press;
  logic                  w_end_go, w_restart_go, w_run;
  logic [NUM_MOLES-1:0]  w_hit, w_miss;
  logic [3:0]            w_hit_cnt, w_miss_cnt;
  logic [PEND_W:0]       w_pend_add;
  logic [PEND_W-1:0]     w_pend_sum;
  logic [8:0]            w_miss_add;
  logic [PEND_W-1:0]     r_pending, r_inflight;
  logic                  r_inj_valid;
  logic [HOLD_W-1:0]     r_holdoff;
  logic [7:0]            r_miss;
  logic                  r_game_reset;

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_ch
    mole_channel #(
      .CNT_W    (CNT_W),
      .ON_TICKS (CNT_W'(ON_TICKS)),
      .OFF_TICKS(OFF_TICKS_VEC[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .i_btn_n(btn_n[g]),
      .i_run  (w_run),
      .i_kill (w_end_go),
      .i_init (w_restart_go),
      .o_led  (mole_led[g]),
      .o_hit  (w_hit[g]),
      .o_miss (w_miss[g])
    );
  end

  assign w_restart_press = r_rst_prev & ~r_rst_sync[SYNC_DEPTH-1];
  assign w_run           = (r_state == ST_PLAY) && !w_end_go;
  assign w_hit_cnt       = popcount8(8'(w_hit));
  assign w_miss_cnt      = popcount8(8'(w_miss));
  assign w_pend_add      = {1'b0, r_pending} + (PEND_W+1)'(w_hit_cnt);
  assign w_pend_sum      = w_pend_add[PEND_W] ? '1 : w_pend_add[PEND_W-1:0];
  assign w_miss_add      = {1'b0, r_miss} + 9'(w_miss_cnt);

  always_comb begin
    w_state_next = r_state;
    w_end_go     = 1'b0;
    w_restart_go = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (score_total >= SCORE_W'(WIN_SCORE)) begin
          w_state_next = ST_END;
          w_end_go     = 1'b1;
        end
      end
      ST_END: begin
        if (w_restart_press && r_holdoff == HOLD_MAX) begin
          w_state_next = ST_PLAY;
          w_restart_go = 1'b1;
        end
      end
      default: w_state_next = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_PLAY;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rst_sync   <= '1;
      r_rst_prev   <= 1'b1;
      r_pending    <= '0;
      r_inflight   <= '0;
      r_inj_valid  <= 1'b0;
      r_holdoff    <= '0;
      r_miss       <= '0;
      r_game_reset <= 1'b0;
    end else begin
      r_rst_sync   <= {r_rst_sync[SYNC_DEPTH-2:0], btn_restart_n};
      r_rst_prev   <= r_rst_sync[SYNC_DEPTH-1];
      r_game_reset <= w_restart_go;
      if (w_restart_go) begin
        r_pending   <= '0;
        r_inflight  <= '0;
        r_inj_valid <= 1'b0;
        r_holdoff   <= '0;
        r_miss      <= '0;
      end else begin
        if (r_inj_valid && inj_ack) r_inj_valid <= 1'b0;
        // Issue and ack are mutually exclusive: issue needs inj_valid low.
        if (r_state == ST_END || w_end_go) begin
          r_pending <= '0;
        end else if (!r_inj_valid && r_pending != '0) begin
          r_inflight  <= r_pending;
          r_pending   <= PEND_W'(w_hit_cnt);
          r_inj_valid <= 1'b1;
        end else begin
          r_pending <= w_pend_sum;
        end
        if (MISS_EN != 0) r_miss <= w_miss_add[8] ? 8'hFF : w_miss_add[7:0];
        if (w_end_go) r_holdoff <= '0;
        else if (r_state == ST_END && r_holdoff != HOLD_MAX) r_holdoff <= r_holdoff + HOLD_W'(1);
      end
    end
  end

  assign inj_valid  = r_inj_valid;
  assign inj_delta  = SCORE_W'(r_inflight);
  assign miss_count = r_miss;
  assign game_reset = r_game_reset;
  assign end_led    = (r_state == ST_END);
  assign in_game    = (r_state == ST_PLAY);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: timing table, directed corner sequences, random run vs reference model.
module tb_mole_game_ctrl;

  localparam int ON   = 10;
  localparam int HOLD = 1000;
  localparam int WIN  = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_n = 4'hF;
  logic        btn_restart_n = 1'b1;
  logic [3:0]  mole_led;
  logic        end_led;
  logic [31:0] score_total = '0;
  logic        inj_valid;
  logic [31:0] inj_delta;
  logic        inj_ack = 1'b0;
  logic [7:0]  miss_count;
  logic        game_reset;
  logic        in_game;

  mole_game_ctrl #(
    .NUM_MOLES(4), .CNT_W(28), .ON_TICKS(ON),
    .OFF_TICKS_VEC({28'd70, 28'd40, 28'd50, 28'd30}),
    .SCORE_W(32), .PEND_W(8), .WIN_SCORE(WIN), .RESTART_HOLDOFF(HOLD), .MISS_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .btn_restart_n(btn_restart_n),
    .mole_led(mole_led), .end_led(end_led), .score_total(score_total),
    .inj_valid(inj_valid), .inj_delta(inj_delta), .inj_ack(inj_ack),
    .miss_count(miss_count), .game_reset(game_reset), .in_game(in_game)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: per-mole lit flag and age in current phase, plus score bookkeeping.
  int OFFS[4] = '{30, 50, 40, 70};
  bit m_lit[4];
  int m_age[4];
  bit m_end, m_valid, m_greset;
  int m_pend, m_infl, m_hold, m_miss;
  bit h1[5], h2[5], h3[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_game_init();
    for (int i = 0; i < 4; i++) begin
      m_lit[i] = 1'b1;
      m_age[i] = 0;
    end
    m_end = 0; m_valid = 0; m_pend = 0; m_infl = 0; m_hold = 0; m_miss = 0;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit pr[5];
    bit pins[5];
    bit win, rgo, old_v;
    int nh, nm;
    nh = 0; nm = 0;
    for (int i = 0; i < 4; i++) pins[i] = btn_n[i];
    pins[4] = btn_restart_n;
    for (int i = 0; i < 5; i++) pr[i] = !h2[i] && h3[i];
    if (!reset) begin
      model_game_init();
      m_greset = 0;
      for (int i = 0; i < 5; i++) begin h1[i] = 1; h2[i] = 1; h3[i] = 1; end
      return;
    end
    win = !m_end && (score_total >= WIN);
    rgo = m_end && pr[4] && (m_hold == HOLD);
    m_greset = rgo;
    if (rgo) begin
      model_game_init();
    end else begin
      old_v = m_valid;
      if (old_v && inj_ack) m_valid = 0;
      if (win) begin
        for (int i = 0; i < 4; i++) m_lit[i] = 0;
      end else if (!m_end) begin
        for (int i = 0; i < 4; i++) begin
          if (pr[i] && m_lit[i]) begin
            nh++;
            m_lit[i] = 0;
            m_age[i] = 0;
          end else begin
            if (pr[i]) nm++;
            m_age[i]++;
            if (m_age[i] == (m_lit[i] ? ON : OFFS[i])) begin
              m_lit[i] = !m_lit[i];
              m_age[i] = 0;
            end
          end
        end
      end
      if (win || m_end) begin
        m_pend = 0;
        m_hold = win ? 0 : sat(m_hold + 1, HOLD);
        m_end  = 1;
      end else if (!old_v && m_pend != 0) begin
        m_infl  = m_pend;
        m_pend  = sat(nh, 255);
        m_valid = 1;
      end else begin
        m_pend = sat(m_pend + nh, 255);
      end
      m_miss = sat(m_miss + nm, 255);
    end
    for (int i = 0; i < 5; i++) begin
      h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = pins[i];
    end
  endtask

  task automatic model_check();
    logic [3:0] el;
    for (int i = 0; i < 4; i++) el[i] = m_lit[i];
    chk("m_mole_led", mole_led, el);
    chk("m_end_led", end_led, m_end);
    chk("m_in_game", in_game, !m_end);
    chk("m_inj_valid", inj_valid, m_valid);
    if (m_valid) chk("m_inj_delta", inj_delta, m_infl);
    chk("m_miss_count", miss_count, m_miss);
    chk("m_game_reset", game_reset, m_greset);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    model_check();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    btn_n = 4'hF; btn_restart_n = 1'b1; inj_ack = 1'b0; score_total = '0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    cyc = 0;
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] btn_n;
    logic [31:0] score;
    logic [3:0] exp_led;
    logic       exp_in_game;
  } vec_t;

  vec_t tbl[15];
  int   e;

  initial begin
    tbl[0]  = '{1,   4'hF, 0, 4'hF, 1'b1};
    tbl[1]  = '{9,   4'hF, 0, 4'hF, 1'b1};
    tbl[2]  = '{10,  4'hF, 0, 4'h0, 1'b1};
    tbl[3]  = '{39,  4'hF, 0, 4'h0, 1'b1};
    tbl[4]  = '{40,  4'hF, 0, 4'h1, 1'b1};
    tbl[5]  = '{49,  4'hF, 0, 4'h1, 1'b1};
    tbl[6]  = '{50,  4'hF, 0, 4'h4, 1'b1};
    tbl[7]  = '{60,  4'hF, 0, 4'h2, 1'b1};
    tbl[8]  = '{70,  4'hF, 0, 4'h0, 1'b1};
    tbl[9]  = '{79,  4'hF, 0, 4'h0, 1'b1};
    tbl[10] = '{80,  4'hF, 0, 4'h9, 1'b1};
    tbl[11] = '{90,  4'hF, 0, 4'h0, 1'b1};
    tbl[12] = '{100, 4'hF, 0, 4'h4, 1'b1};
    tbl[13] = '{110, 4'hF, 0, 4'h0, 1'b1};
    tbl[14] = '{120, 4'hF, 0, 4'h3, 1'b1};

    // Reset state
    do_reset();
    chk("rst_led", mole_led, 4'hF);
    chk("rst_end_led", end_led, 1'b0);
    chk("rst_in_game", in_game, 1'b1);
    chk("rst_valid", inj_valid, 1'b0);
    chk("rst_miss", miss_count, 8'd0);
    chk("rst_game_reset", game_reset, 1'b0);

    // Free-running LED timing
    for (int i = 0; i < 15; i++) begin
      btn_n = tbl[i].btn_n;
      score_total = tbl[i].score;
      run_to(tbl[i].cyc);
      chk("tbl_led", mole_led, tbl[i].exp_led);
      chk("tbl_in_game", in_game, tbl[i].exp_in_game);
    end

    // Single hit and handshake latency
    do_reset();
    run_to(5);
    btn_n[1] = 1'b0;
    run_to(7);
    chk("hit_led_before", mole_led[1], 1'b1);
    tick();
    chk("hit_led_after", mole_led[1], 1'b0);
    chk("hit_valid_early", inj_valid, 1'b0);
    tick();
    btn_n = 4'hF;
    chk("hit_valid", inj_valid, 1'b1);
    chk("hit_delta", inj_delta, 32'd1);
    run_to(12);
    chk("hit_valid_held", inj_valid, 1'b1);
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    chk("hit_valid_drop", inj_valid, 1'b0);
    tick();
    chk("hit_no_reissue", inj_valid, 1'b0);

    // Simultaneous hits with back-pressure
    do_reset();
    run_to(1);
    btn_n = 4'b0010;
    run_to(4);
    chk("sim_led", mole_led, 4'b0010);
    chk("sim_valid_early", inj_valid, 1'b0);
    tick();
    chk("sim_valid", inj_valid, 1'b1);
    chk("sim_delta", inj_delta, 32'd3);
    btn_n = 4'hF;
    run_to(6);
    btn_n = 4'b1101;
    run_to(10);
    btn_n = 4'hF;
    run_to(36);
    btn_n = 4'b1110;
    run_to(40);
    btn_n = 4'hF;
    chk("bp_valid_held", inj_valid, 1'b1);
    chk("bp_delta_held", inj_delta, 32'd3);
    run_to(41);
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    chk("bp_drop", inj_valid, 1'b0);
    tick();
    chk("bp_second_valid", inj_valid, 1'b1);
    chk("bp_second_delta", inj_delta, 32'd2);
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;

    // Miss on a dark mole, then saturation
    do_reset();
    run_to(12);
    btn_n[3] = 1'b0;
    run_to(14);
    chk("miss_before", miss_count, 8'd0);
    tick();
    chk("miss_one", miss_count, 8'd1);
    chk("miss_led", mole_led, 4'h0);
    chk("miss_no_inj", inj_valid, 1'b0);
    btn_n = 4'hF;
    inj_ack = 1'b1;
    for (int i = 0; i < 700; i++) begin
      btn_n[3] = ~btn_n[3];
      tick();
    end
    btn_n = 4'hF;
    inj_ack = 1'b0;
    tick();
    chk("miss_sat", miss_count, 8'd255);

    // Win, holdoff, restart
    do_reset();
    run_to(20);
    score_total = 32'd12;
    tick();
    e = cyc;
    score_total = '0;
    chk("win_in_game", in_game, 1'b0);
    chk("win_end_led", end_led, 1'b1);
    chk("win_led", mole_led, 4'h0);
    run_to(e + 497);
    btn_restart_n = 1'b0;
    run_to(e + 502);
    btn_restart_n = 1'b1;
    chk("early_restart", in_game, 1'b0);
    chk("early_greset", game_reset, 1'b0);
    run_to(e + 997);
    btn_restart_n = 1'b0;
    tick();
    btn_restart_n = 1'b1;
    run_to(e + 1000);
    chk("restart_at_999", in_game, 1'b0);
    btn_restart_n = 1'b0;
    run_to(e + 1002);
    chk("restart_pending", game_reset, 1'b0);
    tick();
    chk("restart_pulse", game_reset, 1'b1);
    chk("restart_in_game", in_game, 1'b1);
    chk("restart_led", mole_led, 4'hF);
    chk("restart_end_led", end_led, 1'b0);
    tick();
    chk("restart_pulse_end", game_reset, 1'b0);
    btn_restart_n = 1'b1;

    // Reset while a request is in flight with pending hits queued
    do_reset();
    run_to(1);
    btn_n = 4'b1110;
    run_to(2);
    btn_n = 4'hF;
    run_to(4);
    btn_n = 4'b0001;
    run_to(6);
    btn_n = 4'hF;
    run_to(35);
    btn_n = 4'b1110;
    run_to(36);
    btn_n = 4'hF;
    run_to(48);
    btn_n = 4'b1011;
    run_to(49);
    btn_n = 4'hF;
    run_to(53);
    chk("mid_valid", inj_valid, 1'b1);
    chk("mid_delta", inj_delta, 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", inj_valid, 1'b0);
    chk("mid_rst_led", mole_led, 4'hF);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_pending", inj_valid, 1'b0);
    end

    // Randomised run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) btn_n[b] = ~btn_n[b];
      if ($urandom_range(0, 15) == 0) btn_restart_n = ~btn_restart_n;
      inj_ack = 1'($urandom_range(0, 1));
      score_total = (i >= 1200 && i < 1206) ? 32'd12 : 32'($urandom_range(0, 11));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Parametrised N-channel whack-a-mole game controller.
- Drives one LED per mole with per-channel on/off timing and detects active-low button hits.
- Accumulates hits into a pending score and hands it over a valid/ack port to the regfile-write arbiter, which injects it into the score register.
- Watches the stored score for the win threshold, then runs the end-game/restart sequence and pulses a one-cycle game reset to the processor and VGA.

Parameters:
- NUM_MOLES, 4, number of mole channels (1..8).
- CNT_W, 28, width of each channel timer.
- ON_TICKS, 25000000, cycles a lit mole stays lit without a hit.
- OFF_TICKS_VEC, {28'd175000000,28'd100000000,28'd125000000,28'd75000000}, packed NUM_MOLES*CNT_W dark periods; channel i uses slice i.
- SCORE_W, 32, score width.
- PEND_W, 8, pending-hit counter width (saturating).
- WIN_SCORE, 12, score_total threshold that ends the game.
- RESTART_HOLDOFF, 1000, end-state cycles before restart is accepted.
- MISS_EN, 1, 1 = presses on a dark mole increment miss_count.

Ports:
- clk  in  1  system clock (25 MHz processor clock domain).
- reset  in  1  synchronous, active-low reset.
- btn_n  in  NUM_MOLES  raw mole buttons, active-low, asynchronous.
- btn_restart_n  in  1  raw restart button, active-low, asynchronous.
- mole_led  out  NUM_MOLES  mole LEDs, 1 = lit.
- end_led  out  1  game-over indicator.
- score_total  in  SCORE_W  current stored score, read back from the regfile.
- inj_valid  out  1  score injection request.
- inj_delta  out  SCORE_W  amount to add; stable while inj_valid is high.
- inj_ack  in  1  arbiter accepted inj_delta this cycle.
- miss_count  out  8  saturating miss counter.
- game_reset  out  1  one-cycle restart pulse.
- in_game  out  1  1 in PLAY.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State PLAY; mole_led all 1; end_led 0.
  - All timers, pending, inflight, miss_count and holdoff cleared.
  - inj_valid 0, game_reset 0, in_game 1.
  - An in-flight request is dropped without ack.
- Inputs:
  - Every button input passes through a 2-flop synchroniser plus a previous-value flop.
  - A press is a synchronised 1->0 edge.
  - A hit is registered on the 3rd clk edge after the pin falls.
- Channel timer (PLAY only):
  - Counts every cycle.
  - Lit and timer == ON_TICKS-1: LED goes 0 and timer goes to 0.
  - Dark and timer == OFF_TICKS[i]-1: LED goes 1 and timer goes to 0.
- Hit (press while lit):
  - LED goes 0 and timer goes to 0 on the same edge; this overrides timer expiry in that cycle.
  - The channel emits a hit strobe.
- Miss: press while dark, MISS_EN=1. miss_count is incremented, saturating at 255; no LED change.
- Pending counter:
  - pending_next = sat(pending + popcount(hit strobes)); saturates at 2^PEND_W-1.
  - Simultaneous hits on k channels add k in one cycle.
- Injection handshake:
  - When inj_valid==0 and pending!=0: next edge inflight<=pending (zero-extended), pending<=popcount(same-cycle hits), inj_valid<=1.
  - inj_valid and inj_delta are held until the cycle inj_ack==1; inj_valid drops on the following edge.
  - The earliest re-assertion is the cycle after it drops.
  - inj_ack while inj_valid==0 is ignored.
  - Hits during an in-flight request accumulate in pending; none are lost below saturation.
- State PLAY -> END when score_total >= WIN_SCORE, sampled each cycle. On that edge:
  - mole_led is forced 0, end_led 1, in_game 0, holdoff 0.
  - Timers freeze.
  - Button hits are ignored; pending is cleared.
  - An in-flight request stays valid until acked.
- END:
  - holdoff increments, saturating at RESTART_HOLDOFF.
  - A restart press with holdoff==RESTART_HOLDOFF produces, on that edge, the same state as reset, plus game_reset=1 for exactly one cycle.
  - A restart press before holdoff saturates is ignored.
- A restart press in PLAY is ignored.

Decomposition:
- Package mole_pkg holds:
  - the state enum {ST_PLAY, ST_END};
  - the synchroniser depth constant (2);
  - the popcount function.
- Sub-module mole_channel holds one synchroniser, edge detector, timer, LED flop and hit/miss strobes. It takes ON_TICKS and OFF_TICKS as parameters and is instantiated NUM_MOLES times via generate.
- The top level holds:
  - the restart synchroniser;
  - pending/inflight and the handshake;
  - the FSM and the holdoff counter.

Test Plan:
- Timing: ON_TICKS=10, OFF_TICKS={70,40,50,30}, no presses. LED0 falls at cycle 10 and rises at cycle 40; LED3 falls at cycle 10 and rises at cycle 80; the pattern repeats exactly.
- Single hit: btn_n[1] falls at cycle 5 with LED1 lit. LED1 goes 0 at cycle 8. inj_valid rises at cycle 9 with inj_delta=1. Ack at cycle 12 drops valid at cycle 13.
- Simultaneous hits and back-pressure: hits on channels 0, 2 and 3 in one cycle give inj_delta=3. While inj_ack is held 0, two more hits arrive. After the ack, a second request follows with inj_delta=2.
- Miss: press on a dark mole with MISS_EN=1. miss_count goes 0->1, LEDs unchanged, no injection. 256 misses saturate miss_count at 255.
- Win and restart: drive score_total=12. The next edge gives in_game=0, end_led=1 and all mole LEDs 0. A restart press at holdoff=500 is ignored. A press after 1000 cycles gives one game_reset pulse, all LEDs 1 and in_game=1.
- Reset mid-request: reset=0 while inj_valid=1 and pending=5. The next edge gives inj_valid=0, pending=0 and mole_led all 1.
